sysbus_arbiter: RTL and testbench

Shares the single Sysbus master port between the instruction-fetch requester (port 0) and the data-memory requester (port 1). It arbitrates, sequences one whole-line transaction at a time, and handles the full bus sequence for each:

- address phase;
- eight write-data beats, or eight read-response beats assembled into a 512-bit line;
- a one-cycle completion pulse back to the granted requester.

It sits between the core's fetch/memory units and the top-level bus pins.

---
 rtl/sysbus_arbiter_pkg.sv | 23 ++
 rtl/sysbus_arbiter_if.sv | 24 ++
 rtl/sysbus_arb_grant.sv | 36 +++
 rtl/sysbus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_arbiter_pkg.sv
// Shared types and constants for the Sysbus two-port line arbiter.
// The round-robin option (SYSBUS_ARB_ROUND_ROBIN_EN) only affects sysbus_arb_grant.
package sysbus_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } arb_state_t;

    localparam int         TAG_WRITE_BIT  = 12;
    localparam logic [3:0] TAG_MEM_TYPE   = 4'h1;
    localparam int         BEATS_PER_LINE = 8;
    localparam logic [2:0] LAST_BEAT      = 3'(BEATS_PER_LINE - 1);

    // A response beat belongs to us only if it is a read response carrying our grant id.
    function automatic logic tag_match(input logic write_bit, input logic id_bit, input logic grant);
        return (write_bit == 1'b0) && (id_bit == grant);
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Sysbus master-port pins; the arbiter drives the master modport, the bus model the slave.
interface sysbus_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
) ();
    logic                  reqcyc;
    logic                  reqack;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  respcyc;
    logic                  respack;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arb_grant.sv
// Combinational grant selection between the fetch (0) and data (1) requesters.
// SYSBUS_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 1 has fixed priority.
module sysbus_arb_grant (
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
    // On contention hand the bus to whichever port did not win last time.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end
`else
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;

    // Data port always wins; fetch only gets the bus when data is quiet.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req1_valid) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus master port between fetch (port 0) and data (port 1), one whole-line
// transaction at a time. Arbitration policy is set by SYSBUS_ARB_ROUND_ROBIN_EN.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BITS      = 512
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 p0_req_valid,
    output logic                 p0_req_ready,
    input  logic [63:0]          p0_req_addr,
    input  logic                 p0_req_write,
    input  logic [LINE_BITS-1:0] p0_req_wdata,
    output logic                 p0_resp_valid,
    output logic [LINE_BITS-1:0] p0_resp_data,

    input  logic                 p1_req_valid,
    output logic                 p1_req_ready,
    input  logic [63:0]          p1_req_addr,
    input  logic                 p1_req_write,
    input  logic [LINE_BITS-1:0] p1_req_wdata,
    output logic                 p1_resp_valid,
    output logic [LINE_BITS-1:0] p1_resp_data,

    sysbus_arbiter_if.master     bus
);

    arb_state_t                state_r;
    logic [2:0]                beat_cnt_r;
    logic                      grant_r;
    logic                      last_grant_r;
    logic                      write_r;
    logic [LINE_BITS-1:0]      wdata_r;
    logic [LINE_BITS-1:0]      line_r;
    logic                      reqcyc_r;
    logic [BUS_DATA_WIDTH-1:0] bus_req_r;
    logic [BUS_TAG_WIDTH-1:0]  reqtag_r;
    logic                      p0_resp_valid_r;
    logic                      p1_resp_valid_r;
    logic [LINE_BITS-1:0]      p0_resp_data_r;
    logic [LINE_BITS-1:0]      p1_resp_data_r;

    logic                      grant_valid_s;
    logic                      grant_id_s;
    logic                      grant_ok_s;
    logic [63:0]               sel_addr_s;
    logic                      sel_write_s;
    logic [LINE_BITS-1:0]      sel_wdata_s;
    logic [BUS_TAG_WIDTH-1:0]  req_tag_s;
    logic [2:0]                next_cnt_s;
    logic [BUS_DATA_WIDTH-1:0] next_beat_s;
    logic [LINE_BITS-1:0]      line_merged_s;
    logic                      beat_keep_s;
    logic                      unused_bits_s;

    sysbus_arb_grant u_grant (
        .req0_valid  (p0_req_valid),
        .req1_valid  (p1_req_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    assign grant_ok_s    = ~reset & (state_r == S_IDLE) & grant_valid_s;
    assign p0_req_ready  = grant_ok_s & ~grant_id_s;
    assign p1_req_ready  = grant_ok_s &  grant_id_s;

    // Stray beats are drained while idle; during RESP every beat is consumed, kept or not.
    assign bus.respack   = ~reset & bus.respcyc & ((state_r == S_IDLE) | (state_r == S_RESP));
    assign bus.reqcyc    = reqcyc_r;
    assign bus.req       = bus_req_r;
    assign bus.reqtag    = reqtag_r;

    assign p0_resp_valid = p0_resp_valid_r;
    assign p1_resp_valid = p1_resp_valid_r;
    assign p0_resp_data  = p0_resp_data_r;
    assign p1_resp_data  = p1_resp_data_r;

    assign unused_bits_s = ^{p0_req_addr[5:0], p1_req_addr[5:0], bus.resptag[BUS_TAG_WIDTH-2:1]};

    // Winner's request fields, outgoing tag, next write beat and line with the current beat merged.
    always_comb begin
        if (grant_id_s) begin
            sel_addr_s  = p1_req_addr;
            sel_write_s = p1_req_write;
            sel_wdata_s = p1_req_wdata;
        end else begin
            sel_addr_s  = p0_req_addr;
            sel_write_s = p0_req_write;
            sel_wdata_s = p0_req_wdata;
        end
        req_tag_s                = '0;
        req_tag_s[TAG_WRITE_BIT] = sel_write_s;
        req_tag_s[11:8]          = TAG_MEM_TYPE;
        req_tag_s[0]             = grant_id_s;
        next_cnt_s               = beat_cnt_r + 3'd1;
        next_beat_s              = wdata_r[next_cnt_s*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        line_merged_s            = line_r;
        line_merged_s[beat_cnt_r*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus.resp;
        beat_keep_s = bus.respcyc & tag_match(bus.resptag[TAG_WRITE_BIT], bus.resptag[0], grant_r);
    end

    // Transaction sequencer; all bus and completion outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            beat_cnt_r      <= 3'd0;
            grant_r         <= 1'b0;
            last_grant_r    <= 1'b1;
            write_r         <= 1'b0;
            wdata_r         <= '0;
            line_r          <= '0;
            reqcyc_r        <= 1'b0;
            bus_req_r       <= '0;
            reqtag_r        <= '0;
            p0_resp_valid_r <= 1'b0;
            p1_resp_valid_r <= 1'b0;
            p0_resp_data_r  <= '0;
            p1_resp_data_r  <= '0;
        end else begin
            p0_resp_valid_r <= 1'b0;
            p1_resp_valid_r <= 1'b0;
            p0_resp_data_r  <= '0;
            p1_resp_data_r  <= '0;
            case (state_r)
                S_IDLE: begin
                    if (grant_valid_s) begin
                        grant_r      <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        write_r      <= sel_write_s;
                        wdata_r      <= sel_wdata_s;
                        line_r       <= '0;
                        beat_cnt_r   <= 3'd0;
                        reqcyc_r     <= 1'b1;
                        bus_req_r    <= {sel_addr_s[63:6], 6'b000000};
                        reqtag_r     <= req_tag_s;
                        state_r      <= S_ADDR;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (bus.reqack) begin
                        if (write_r) begin
                            bus_req_r <= wdata_r[BUS_DATA_WIDTH-1:0];
                            state_r   <= S_WDATA;
                        end else begin
                            reqcyc_r  <= 1'b0;
                            bus_req_r <= '0;
                            reqtag_r  <= '0;
                            state_r   <= S_RESP;
                        end
                    end else begin
                        state_r <= S_ADDR;
                    end
                end
                S_WDATA: begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        reqcyc_r        <= 1'b0;
                        bus_req_r       <= '0;
                        reqtag_r        <= '0;
                        beat_cnt_r      <= 3'd0;
                        p0_resp_valid_r <= ~grant_r;
                        p1_resp_valid_r <= grant_r;
                        state_r         <= S_DONE;
                    end else begin
                        beat_cnt_r <= next_cnt_s;
                        bus_req_r  <= next_beat_s;
                    end
                end
                S_RESP: begin
                    if (beat_keep_s) begin
                        line_r <= line_merged_s;
                        if (beat_cnt_r == LAST_BEAT) begin
                            beat_cnt_r      <= 3'd0;
                            p0_resp_valid_r <= ~grant_r;
                            p1_resp_valid_r <= grant_r;
                            if (grant_r) begin
                                p1_resp_data_r <= line_merged_s;
                            end else begin
                                p0_resp_data_r <= line_merged_s;
                            end
                            state_r <= S_DONE;
                        end else begin
                            beat_cnt_r <= next_cnt_s;
                        end
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: a transaction table plus hand-built corner sequences.
module tb_sysbus_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic         p0_req_ready, p1_req_ready;
    logic [63:0]  p0_req_addr = '0, p1_req_addr = '0;
    logic         p0_req_write = 1'b0, p1_req_write = 1'b0;
    logic [511:0] p0_req_wdata = '0, p1_req_wdata = '0;
    logic         p0_resp_valid, p1_resp_valid;
    logic [511:0] p0_resp_data, p1_resp_data;

    int errors = 0;
    int checks = 0;

    sysbus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

    sysbus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .p0_req_valid  (p0_req_valid),
        .p0_req_ready  (p0_req_ready),
        .p0_req_addr   (p0_req_addr),
        .p0_req_write  (p0_req_write),
        .p0_req_wdata  (p0_req_wdata),
        .p0_resp_valid (p0_resp_valid),
        .p0_resp_data  (p0_resp_data),
        .p1_req_valid  (p1_req_valid),
        .p1_req_ready  (p1_req_ready),
        .p1_req_addr   (p1_req_addr),
        .p1_req_write  (p1_req_write),
        .p1_req_wdata  (p1_req_wdata),
        .p1_resp_valid (p1_resp_valid),
        .p1_resp_data  (p1_resp_data),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    typedef struct {
        int          port;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] exp_addr;
        logic [63:0] base;
        int          ack_delay;
        int          stray_at;
        logic [12:0] exp_tag;
    } txn_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic wr,
                           input logic [63:0] a, input logic [511:0] wd);
        if (port == 1) begin
            p1_req_valid = v; p1_req_write = wr; p1_req_addr = a; p1_req_wdata = wd;
        end else begin
            p0_req_valid = v; p0_req_write = wr; p0_req_addr = a; p0_req_wdata = wd;
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_txn(input txn_t t);
        logic [511:0] line;
        int kept;
        int n;
        for (int k = 0; k < 8; k++) line[k*64 +: 64] = t.base + 64'(k);
        tick();
        set_req(t.port, 1'b1, t.wr, t.addr, t.wr ? line : 512'd0);
        #1;
        check("grant ready", (t.port == 1) ? p1_req_ready : p0_req_ready, 1'b1);
        check("other ready", (t.port == 1) ? p0_req_ready : p1_req_ready, 1'b0);
        tick();
        set_req(t.port, 1'b0, 1'b0, 64'd0, 512'd0);
        for (int d = 0; d < t.ack_delay; d++) begin
            #1;
            check("stall reqcyc", bus.reqcyc, 1'b1);
            check("stall addr held", bus.req, t.exp_addr);
            tick();
        end
        bus.reqack = 1'b1;
        #1;
        check("addr reqcyc", bus.reqcyc, 1'b1);
        check("addr beat", bus.req, t.exp_addr);
        check("addr tag", bus.reqtag, t.exp_tag);
        tick();
        bus.reqack = 1'b0;
        if (t.wr) begin
            for (int k = 0; k < 8; k++) begin
                #1;
                check("wdata reqcyc", bus.reqcyc, 1'b1);
                check("wdata beat", bus.req, t.base + 64'(k));
                check("wdata tag", bus.reqtag, t.exp_tag);
                tick();
            end
        end else begin
            kept = 0;
            n = 0;
            while (kept < 8) begin
                bus.respcyc = 1'b1;
                if (n == t.stray_at) begin
                    bus.resp    = 64'hDEAD_BEEF_0000_0000;
                    bus.resptag = 13'((t.port == 1) ? 0 : 1);
                end else begin
                    bus.resp    = t.base + 64'(kept);
                    bus.resptag = 13'h0A00 | 13'(t.port);
                    kept++;
                end
                #1;
                check("resp ack", bus.respack, 1'b1);
                tick();
                n++;
            end
            bus.respcyc = 1'b0;
            bus.resptag = '0;
        end
        #1;
        check("done valid", (t.port == 1) ? p1_resp_valid : p0_resp_valid, 1'b1);
        check("done other valid", (t.port == 1) ? p0_resp_valid : p1_resp_valid, 1'b0);
        check("done data", (t.port == 1) ? p1_resp_data : p0_resp_data, t.wr ? 512'd0 : line);
        check("done reqcyc", bus.reqcyc, 1'b0);
        tick();
        check("pulse ends", p0_resp_valid | p1_resp_valid, 1'b0);
    endtask

    initial begin
        txn_t tbl[4];
        int   exp_seq[4];
        int   ngrants;
        int   last_cyc;
        logic seen;

        tbl[0] = '{0, 1'b0, 64'h1000, 64'h1000, 64'h0,   0, -1, 13'h0100};
        tbl[1] = '{1, 1'b1, 64'h2040, 64'h2040, 64'hA0,  0, -1, 13'h1101};
        tbl[2] = '{1, 1'b0, 64'h303F, 64'h3000, 64'h100, 5,  3, 13'h0101};
        tbl[3] = '{0, 1'b1, 64'h40A5, 64'h4080, 64'h55,  2, -1, 13'h1100};

        bus.reqack = 1'b0; bus.respcyc = 1'b0; bus.resp = '0; bus.resptag = '0;

        // Reset state, including ready suppressed while reset is held.
        p0_req_valid = 1'b1;
        tick();
        #1;
        check("ready under reset", p0_req_ready, 1'b0);
        tick();
        reset = 1'b0;
        p0_req_valid = 1'b0;
        #1;
        check("reset reqcyc", bus.reqcyc, 1'b0);
        check("reset req", bus.req, 64'd0);
        check("reset reqtag", bus.reqtag, 13'd0);
        check("reset respack", bus.respack, 1'b0);
        check("reset resp_valid", p0_resp_valid | p1_resp_valid, 1'b0);
        check("reset resp_data", p0_resp_data | p1_resp_data, 512'd0);

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Drain of stray response beats while idle.
        tick();
        bus.respcyc = 1'b1; bus.resp = 64'h123; bus.resptag = 13'h0000;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("idle drain ack", bus.respack, 1'b1);
            seen = seen | p0_resp_valid | p1_resp_valid;
            tick();
        end
        bus.respcyc = 1'b0;
        #1;
        check("idle drain no resp", seen | p0_resp_valid | p1_resp_valid, 1'b0);

        // Reset in RESP after three beats abandons the read.
        tick();
        set_req(0, 1'b1, 1'b0, 64'h7000, 512'd0);
        tick();
        set_req(0, 1'b0, 1'b0, 64'd0, 512'd0);
        bus.reqack = 1'b1;
        tick();
        bus.reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.respcyc = 1'b1; bus.resp = 64'(k + 9); bus.resptag = 13'd0;
            tick();
        end
        bus.respcyc = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midreset reqcyc", bus.reqcyc, 1'b0);
        check("midreset req", bus.req, 64'd0);
        check("midreset respack", bus.respack, 1'b0);
        check("midreset valid", p0_resp_valid | p1_resp_valid, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen = seen | p0_resp_valid | p1_resp_valid;
        end
        check("midreset no late resp", seen, 1'b0);
        run_txn('{0, 1'b0, 64'h7000, 64'h7000, 64'h300, 0, -1, 13'h0100});

        // Contention: both ports request writes continuously from a fresh reset.
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        do_reset();
        set_req(0, 1'b1, 1'b1, 64'h5000, 512'd0);
        set_req(1, 1'b1, 1'b1, 64'h6000, 512'd0);
        bus.reqack = 1'b1;
        ngrants = 0;
        last_cyc = 0;
        for (int c = 0; c < 60 && ngrants < 4; c++) begin
            #1;
            if (p0_req_ready || p1_req_ready) begin
                check("contention one-hot", p0_req_ready & p1_req_ready, 1'b0);
                check("contention winner", 512'(p1_req_ready), 512'(exp_seq[ngrants]));
                if (ngrants > 0) check("grant spacing", 512'(c - last_cyc), 512'd11);
                last_cyc = c;
                ngrants++;
            end
            tick();
        end
        check("contention grant count", 512'(ngrants), 512'd4);
        set_req(0, 1'b0, 1'b0, 64'd0, 512'd0);
        set_req(1, 1'b0, 1'b0, 64'd0, 512'd0);
        bus.reqack = 1'b0;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
